pump_alternator_scheduler: RTL and testbench



---
 rtl/pump_alternator_scheduler.sv | 140 ++++++++++++++
 tb/tb_pump_alternator_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pump_alternator_scheduler.sv
// Two-pump alternator: min on/off timing, dry-run watchdog, per-pump failover.
// Outputs are registered from next-state so relays follow state_dbg exactly.
module pump_alternator_scheduler #(
  parameter int CLK_HZ          = 25_000_000,
  parameter int MIN_ON_CYC      = 25_000_000,
  parameter int MIN_OFF_CYC     = 50_000_000,
  parameter int DRY_TIMEOUT_CYC = 250_000_000,
  parameter int CNT_W           = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pump_req,
  input  logic       en_auto,
  input  logic [2:0] lvl_sup,
  input  logic       fault_clr,
  output logic       pump_a_on,
  output logic       pump_b_on,
  output logic       active_b,
  output logic [1:0] pump_fault,
  output logic       fault,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LIM = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OF_LIM = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(DRY_TIMEOUT_CYC - 1);

  if (CLK_HZ < 1 || MIN_ON_CYC < 1 || MIN_OFF_CYC < 1 ||
      DRY_TIMEOUT_CYC < 2 || CNT_W < 2) begin : g_bad_param
    $error("pump_alternator_scheduler: bad parameters");
  end

  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic [1:0]       flt_q, flt_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [2:0]       ref_q, ref_d;
  logic             pa_q, pb_q, fault_q;
  logic             prog;

  assign prog = (lvl_sup <= 3'd4) && (lvl_sup > ref_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    flt_d   = fault_clr ? 2'b00 : flt_q;
    on_d    = on_q;
    off_d   = off_q;
    wd_d    = wd_q;
    ref_d   = ref_q;
    unique case (state_q)
      S_IDLE: begin
        if (en_auto && pump_req && !(&flt_q)) begin
          state_d = S_RUN;
          sel_d   = flt_q[sel_q] ? ~sel_q : sel_q;
          on_d    = '0;
          wd_d    = '0;
          ref_d   = lvl_sup;
        end
      end
      S_RUN: begin
        on_d = (&on_q) ? on_q : on_q + ONE;
        if (prog) begin
          ref_d = lvl_sup;
          wd_d  = '0;
        end else begin
          wd_d  = wd_q + ONE;
        end
        if (!en_auto) begin
          state_d = S_COOL;
          sel_d   = ~sel_q;
          off_d   = '0;
        end else if (!prog && wd_q == WD_LIM) begin
          flt_d[sel_q] = 1'b1;
          if (flt_d[~sel_q]) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_COOL;
            sel_d   = ~sel_q;
            off_d   = '0;
          end
        end else if (!pump_req && on_q >= ON_LIM) begin
          state_d = S_COOL;
          sel_d   = ~sel_q;
          off_d   = '0;
        end
      end
      S_COOL: begin
        off_d = off_q + ONE;
        if (off_q == OF_LIM) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      flt_q   <= 2'b00;
      on_q    <= '0;
      off_q   <= '0;
      wd_q    <= '0;
      ref_q   <= 3'd0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      flt_q   <= flt_d;
      on_q    <= on_d;
      off_q   <= off_d;
      wd_q    <= wd_d;
      ref_q   <= ref_d;
      pa_q    <= (state_d == S_RUN) && !sel_d;
      pb_q    <= (state_d == S_RUN) && sel_d;
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign pump_a_on  = pa_q;
  assign pump_b_on  = pb_q;
  assign active_b   = sel_q;
  assign pump_fault = flt_q;
  assign fault      = fault_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pump_alternator_scheduler.sv
// Bench for pump_alternator_scheduler: vector table, corner sequences,
// and random stimulus against a cycle-count reference model.
module tb_pump_alternator_scheduler;

  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 6;
  localparam int DRY     = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pump_req = 1'b0;
  logic       en_auto = 1'b0;
  logic [2:0] lvl_sup = 3'd0;
  logic       fault_clr = 1'b0;
  logic       pump_a_on, pump_b_on, active_b, fault;
  logic [1:0] pump_fault, state_dbg;

  int passed = 0;
  int total  = 0;

  pump_alternator_scheduler #(
    .CLK_HZ(1000), .MIN_ON_CYC(MIN_ON), .MIN_OFF_CYC(MIN_OFF),
    .DRY_TIMEOUT_CYC(DRY), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pump_req(pump_req), .en_auto(en_auto),
    .lvl_sup(lvl_sup), .fault_clr(fault_clr),
    .pump_a_on(pump_a_on), .pump_b_on(pump_b_on),
    .active_b(active_b), .pump_fault(pump_fault),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running, 2 cooling, 3 faulted.
  int       m_mode, m_ran, m_stale, m_cool, m_best;
  bit       m_pick;
  bit [1:0] m_bad;

  task model_step();
    bit [1:0] bn;
    bit prog, leave;
    if (rst) begin
      m_mode = 0; m_pick = 0; m_bad = 0;
      m_ran = 0; m_stale = 0; m_cool = 0; m_best = 0;
    end else begin
      bn = fault_clr ? 2'b00 : m_bad;
      leave = 0;
      case (m_mode)
        0: if (en_auto && pump_req && m_bad != 2'b11) begin
          m_mode = 1;
          if (m_bad[m_pick]) m_pick = !m_pick;
          m_ran = 0; m_stale = 0; m_best = int'(lvl_sup);
        end
        1: begin
          m_ran++;
          prog = (lvl_sup <= 4) && (int'(lvl_sup) > m_best);
          if (prog) begin
            m_best = int'(lvl_sup);
            m_stale = 0;
          end else m_stale++;
          if (!en_auto) leave = 1;
          else if (m_stale == DRY) begin
            bn[m_pick] = 1'b1;
            if (bn[!m_pick]) m_mode = 3;
            else leave = 1;
          end else if (!pump_req && m_ran >= MIN_ON) leave = 1;
          if (leave) begin
            m_mode = 2; m_cool = 0; m_pick = !m_pick;
          end
        end
        2: begin
          m_cool++;
          if (m_cool == MIN_OFF) m_mode = 0;
        end
        default: if (fault_clr) m_mode = 0;
      endcase
      m_bad = bn;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    logic r, q, e, c;
    logic [2:0] l;
    logic a, b, ab, f;
    logic [1:0] pf, st;
  } vec_t;

  function automatic vec_t v(logic r, logic q, logic e, logic a,
                             logic b, logic ab, logic [1:0] st);
    vec_t t;
    t.r = r; t.q = q; t.e = e; t.c = 0; t.l = 3'd0;
    t.a = a; t.b = b; t.ab = ab; t.f = 0; t.pf = 2'b00; t.st = st;
    return t;
  endfunction

  vec_t tv[16];
  int n, cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = v(1, 0, 0, 0, 0, 0, 2'd0);
    tv[1]  = v(1, 0, 0, 0, 0, 0, 2'd0);
    tv[2]  = v(0, 1, 1, 1, 0, 0, 2'd1);
    tv[3]  = v(0, 0, 1, 1, 0, 0, 2'd1);
    tv[4]  = v(0, 0, 1, 1, 0, 0, 2'd1);
    tv[5]  = v(0, 0, 1, 1, 0, 0, 2'd1);
    tv[6]  = v(0, 0, 1, 0, 0, 1, 2'd2);
    tv[7]  = v(0, 0, 1, 0, 0, 1, 2'd2);
    tv[8]  = v(0, 0, 1, 0, 0, 1, 2'd2);
    tv[9]  = v(0, 0, 1, 0, 0, 1, 2'd2);
    tv[10] = v(0, 0, 1, 0, 0, 1, 2'd2);
    tv[11] = v(0, 0, 1, 0, 0, 1, 2'd2);
    tv[12] = v(0, 0, 1, 0, 0, 1, 2'd0);
    tv[13] = v(0, 1, 1, 0, 1, 1, 2'd1);
    tv[14] = v(0, 1, 0, 0, 0, 0, 2'd2);
    tv[15] = v(0, 0, 0, 0, 0, 0, 2'd2);
    for (int i = 0; i < 16; i++) begin
      rst = tv[i].r; pump_req = tv[i].q; en_auto = tv[i].e;
      lvl_sup = tv[i].l; fault_clr = tv[i].c;
      tick();
      chk($sformatf("vec%0d a", i), int'(pump_a_on), int'(tv[i].a));
      chk($sformatf("vec%0d b", i), int'(pump_b_on), int'(tv[i].b));
      chk($sformatf("vec%0d act_b", i), int'(active_b), int'(tv[i].ab));
      chk($sformatf("vec%0d pf", i), int'(pump_fault), int'(tv[i].pf));
      chk($sformatf("vec%0d fault", i), int'(fault), int'(tv[i].f));
      chk($sformatf("vec%0d st", i), int'(state_dbg), int'(tv[i].st));
    end

    // Normal run of A, then B after the full off time.
    rst = 1; tick(); tick();
    rst = 0; en_auto = 1; pump_req = 1; lvl_sup = 0;
    tick();
    chk("seqA a rises", int'(pump_a_on), 1);
    for (int k = 1; k < 10; k++) begin
      if (k % 5 == 0) lvl_sup = lvl_sup + 3'd1;
      tick();
    end
    chk("seqA a held", int'(pump_a_on), 1);
    pump_req = 0;
    tick();
    chk("seqA a falls", int'(pump_a_on), 0);
    chk("seqA act_b", int'(active_b), 1);
    chk("seqA cool", int'(state_dbg), 2);
    pump_req = 1;
    n = 0;
    while (!pump_b_on && n < 40) begin tick(); n++; end
    chk("seqA b delay from last a-on", n + 1, 8);
    chk("seqA a off", int'(pump_a_on), 0);

    // Dry run on both pumps, then clear.
    rst = 1; tick(); tick();
    rst = 0; en_auto = 1; pump_req = 1; lvl_sup = 1;
    tick();
    cnt = 0;
    while (pump_a_on && cnt < 60) begin cnt++; tick(); end
    chk("seqB a run len", cnt, DRY);
    chk("seqB pf A", int'(pump_fault), 1);
    chk("seqB cool", int'(state_dbg), 2);
    n = 0;
    while (!pump_b_on && n < 40) begin tick(); n++; end
    chk("seqB b starts", int'(pump_b_on), 1);
    cnt = 0;
    while (pump_b_on && cnt < 60) begin cnt++; tick(); end
    chk("seqB b run len", cnt, DRY);
    chk("seqB pf both", int'(pump_fault), 3);
    chk("seqB fault", int'(fault), 1);
    chk("seqB st", int'(state_dbg), 3);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("seqB clr pf", int'(pump_fault), 0);
    chk("seqB clr st", int'(state_dbg), 0);
    chk("seqB clr act_b", int'(active_b), 1);
    pump_req = 0;

    // Timeout on the same cycle req falls, then reset mid-run.
    rst = 1; tick(); tick();
    rst = 0; en_auto = 1; pump_req = 1; lvl_sup = 2;
    tick();
    for (int k = 0; k < DRY - 1; k++) tick();
    chk("seqC a before timeout", int'(pump_a_on), 1);
    pump_req = 0;
    tick();
    chk("seqC pf", int'(pump_fault), 1);
    chk("seqC st", int'(state_dbg), 2);
    chk("seqC a off", int'(pump_a_on), 0);
    pump_req = 1;
    n = 0;
    while (!pump_b_on && n < 40) begin tick(); n++; end
    chk("seqC b starts", int'(pump_b_on), 1);
    tick(); tick();
    rst = 1; tick();
    chk("seqC rst a", int'(pump_a_on), 0);
    chk("seqC rst b", int'(pump_b_on), 0);
    chk("seqC rst st", int'(state_dbg), 0);
    chk("seqC rst pf", int'(pump_fault), 0);
    chk("seqC rst act_b", int'(active_b), 0);
    rst = 0;

    // Random stimulus against the model.
    en_auto = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) pump_req = !pump_req;
      if ($urandom_range(0, 99) == 0) en_auto = !en_auto;
      if ($urandom_range(0, 29) == 0) lvl_sup = 3'($urandom_range(0, 7));
      fault_clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      chk("rnd a", int'(pump_a_on), int'(m_mode == 1 && !m_pick));
      chk("rnd b", int'(pump_b_on), int'(m_mode == 1 && m_pick));
      chk("rnd act_b", int'(active_b), int'(m_pick));
      chk("rnd pf", int'(pump_fault), int'(m_bad));
      chk("rnd fault", int'(fault), int'(m_mode == 3));
      chk("rnd st", int'(state_dbg), m_mode);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
